flappy_sfx_sequencer: RTL
=========================

# flappy_sfx_sequencer

Game-event sound-effect sequencer feeding the FlappyBird audio PWM stage. Converts single-cycle game events (flap, score, crash) into a timed sequence of square-wave notes and emits a per-clock duty sample plus an audio-enable for the downstream PWM/audio-jack block. Runs on the 100 MHz system clock; the PWM stage consumes `sample_out` directly.

## Interface
- `NOTE_TICKS`, 5_000_000: clocks per note (50 ms).
- `GAP_TICKS`, 500_000: silent clocks after each note (5 ms).
- `AMPLITUDE`, 8'd192: sample value while square wave is high.
- `TONE_DIV_SHIFT`, 0: right-shift applied to ROM half-periods (bench uses 10).
- `clk`  in  1  system clock, 100 MHz; all logic rising-edge.
- `reset`  in  1  synchronous, active-high.
- `flap_evt`  in  1  one-cycle pulse, bird flapped.
- `score_evt`  in  1  one-cycle pulse, pipe cleared.
- `crash_evt`  in  1  one-cycle pulse, collision.
- `mute`  in  1  level; silences output, sequencing continues.
- `sample_out`  out  8  duty sample to PWM stage.
- `audio_en`  out  1  enable for audio amplifier.
- `busy`  out  1  effect currently playing (PLAY or GAP).

## Operation
- Note ROM (19-bit half-periods in clocks; 0 = rest):
  - flap: 56818, 42553.
  - score: 37908, 31888, 23889.
  - crash: 227273, 0, 340136, 454545.
- Effective half-period = ROM value >> TONE_DIV_SHIFT; result 0 is a rest.
- Priority crash > score > flap. Simultaneous events: highest wins.
- Event with priority ≥ current effect: restart at note 0 of new effect. Lower priority during playback: ignored.
- FSM states:
  - IDLE: wait for event.
  - PLAY: tone for NOTE_TICKS clocks.
  - GAP: silence for GAP_TICKS clocks; then next note in PLAY, or IDLE after the last note.
- Tone: phase counter counts 0..hp−1; at hp−1, toggle square and clear counter. Square starts high at note start.
- `sample_out` = AMPLITUDE when PLAY ∧ square ∧ hp≠0 ∧ ¬mute; else 0.
- `audio_en` = busy ∧ ¬mute.
- Reset values: state IDLE; `sample_out` 0; `audio_en` 0; `busy` 0; all counters 0.

## Timing
- Event accepted at edge N: PLAY, `busy`=1, `sample_out`=AMPLITUDE, all visible after edge N+1 (1-cycle latency, registered outputs).
- First square toggle hp clocks after note start. Period is 2·hp clocks.
- Note length is exactly NOTE_TICKS clocks; gap exactly GAP_TICKS.
- Effect of k notes lasts k·(NOTE_TICKS+GAP_TICKS) clocks, then `busy` drops.
- Restart mid-note: phase, note and duration counters clear on the same edge the event is accepted.
- Reset asserted mid-effect: IDLE and zeroed outputs on the next edge. An event in the reset cycle is dropped.
- `mute` takes effect combinationally on the next registered output (1 cycle).

## Structure
- Package `flappy_sfx_pkg`:
  - `sfx_id_t` enum (NONE, FLAP, SCORE, CRASH).
  - Note ROM constants.
  - Per-effect note counts and base offsets.
  - `HP_W`=19.
- Sub-module `sfx_tone_gen`:
  - Inputs: phase counter, square flop, `hp`, `restart`.
  - Output: square.
- Top holds the FSM, note index, duration counter and output registers.

## Test plan
- Bench params: NOTE_TICKS=100, GAP_TICKS=10, TONE_DIV_SHIFT=10.
- Reset, then idle 50 clocks → `sample_out`=0, `audio_en`=0, `busy`=0 throughout.
- flap_evt pulse → `sample_out`=192 one cycle later. Square half-period 55 clocks for 100 clocks, then 41 clocks. `busy` high for exactly 220 clocks.
- crash_evt → note 2 is a rest: `sample_out`=0 for 100 clocks, `busy` stays 1. Total `busy` time 440 clocks.
- score playing at note 1, flap_evt → ignored. crash_evt at clock 150 → crash note 0 (hp 221) starts next cycle.
- flap_evt ∧ crash_evt in the same cycle → crash sequence plays.
- Reset asserted at clock 60 of a score effect → next cycle all outputs 0, `busy`=0. mute=1 during flap → `sample_out`=0, `audio_en`=0, `busy` still 1 for 220 clocks.

Source files
------------

// File: rtl/flappy_sfx_pkg.sv
// Shared types, note ROM and per-effect tables for the FlappyBird sound-effect sequencer.
package flappy_sfx_pkg;

  localparam int HP_W = 19;

  typedef enum logic [1:0] {
    SFX_NONE  = 2'd0,
    SFX_FLAP  = 2'd1,
    SFX_SCORE = 2'd2,
    SFX_CRASH = 2'd3
  } sfx_id_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } sfx_state_t;

  // Flat ROM layout: flap at 0..1, score at 2..4, crash at 5..8.
  localparam logic [3:0] FLAP_BASE   = 4'd0;
  localparam logic [3:0] SCORE_BASE  = 4'd2;
  localparam logic [3:0] CRASH_BASE  = 4'd5;
  localparam logic [2:0] FLAP_COUNT  = 3'd2;
  localparam logic [2:0] SCORE_COUNT = 3'd3;
  localparam logic [2:0] CRASH_COUNT = 3'd4;

  // Note half-periods in clocks; zero marks a rest.
  function automatic logic [HP_W-1:0] note_rom(input logic [3:0] idx);
    logic [HP_W-1:0] hp;
    case (idx)
      4'd0:    hp = 19'd56818;
      4'd1:    hp = 19'd42553;
      4'd2:    hp = 19'd37908;
      4'd3:    hp = 19'd31888;
      4'd4:    hp = 19'd23889;
      4'd5:    hp = 19'd227273;
      4'd6:    hp = 19'd0;
      4'd7:    hp = 19'd340136;
      4'd8:    hp = 19'd454545;
      default: hp = 19'd0;
    endcase
    return hp;
  endfunction

  function automatic logic [3:0] fx_base(input sfx_id_t fx);
    logic [3:0] b;
    case (fx)
      SFX_FLAP:  b = FLAP_BASE;
      SFX_SCORE: b = SCORE_BASE;
      SFX_CRASH: b = CRASH_BASE;
      default:   b = 4'd0;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] fx_count(input sfx_id_t fx);
    logic [2:0] n;
    case (fx)
      SFX_FLAP:  n = FLAP_COUNT;
      SFX_SCORE: n = SCORE_COUNT;
      SFX_CRASH: n = CRASH_COUNT;
      default:   n = 3'd0;
    endcase
    return n;
  endfunction

  // Highest-priority pending event: crash over score over flap.
  function automatic sfx_id_t pick_event(input logic flap, input logic score, input logic crash);
    sfx_id_t e;
    if (crash) begin
      e = SFX_CRASH;
    end else if (score) begin
      e = SFX_SCORE;
    end else if (flap) begin
      e = SFX_FLAP;
    end else begin
      e = SFX_NONE;
    end
    return e;
  endfunction

endpackage

// File: rtl/flappy_sfx_sequencer_tone_gen.sv
// Square-wave generator: phase counter and square flop, restarted high at every note start.
module sfx_tone_gen
  import flappy_sfx_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_restart,
  input  logic            i_enable,
  input  logic [HP_W-1:0] i_hp,
  output logic            o_square
);

  logic [HP_W-1:0] r_phase;
  logic            r_square;

  // Count 0..hp-1 and toggle at the top; hold high with a cleared phase when idle, restarting or resting.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_restart || !i_enable || (i_hp == {HP_W{1'b0}})) begin
      r_phase  <= {HP_W{1'b0}};
      r_square <= 1'b1;
    end else if (r_phase == (i_hp - HP_W'(1))) begin
      r_phase  <= {HP_W{1'b0}};
      r_square <= ~r_square;
    end else begin
      r_phase  <= r_phase + HP_W'(1);
      r_square <= r_square;
    end
  end

  assign o_square = r_square;

endmodule

// File: rtl/flappy_sfx_sequencer.sv
// Game-event sound-effect sequencer: turns flap/score/crash pulses into timed square-wave notes.
module flappy_sfx_sequencer
  import flappy_sfx_pkg::*;
#(
  parameter int          NOTE_TICKS     = 5_000_000,
  parameter int          GAP_TICKS      = 500_000,
  parameter logic [7:0]  AMPLITUDE      = 8'd192,
  parameter int          TONE_DIV_SHIFT = 0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_flap_evt,
  input  logic       i_score_evt,
  input  logic       i_crash_evt,
  input  logic       i_mute,
  output logic [7:0] o_sample_out,
  output logic       o_audio_en,
  output logic       o_busy
);

  localparam int DUR_MAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int DUR_W   = $clog2(DUR_MAX + 1);
  localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_TICKS - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'(GAP_TICKS - 1);

  sfx_state_t       r_state;
  sfx_id_t          r_fx;
  logic [1:0]       r_note;
  logic [DUR_W-1:0] r_dur;
  logic [7:0]       r_sample;
  logic             r_audio_en;
  logic             r_busy;

  sfx_id_t          w_evt;
  logic             w_accept;
  logic             w_last_note;
  logic             w_gap_done;
  logic             w_restart;
  logic [3:0]       w_rom_idx;
  logic [HP_W-1:0]  w_hp;
  logic             w_square;
  logic             w_tone_en;

  // Event arbitration, current note lookup and note-start detection.
  always_comb begin
    w_evt       = pick_event(i_flap_evt, i_score_evt, i_crash_evt);
    w_accept    = (w_evt != SFX_NONE) && (w_evt >= r_fx);
    w_rom_idx   = fx_base(r_fx) + {2'b00, r_note};
    w_hp        = note_rom(w_rom_idx) >> TONE_DIV_SHIFT;
    w_last_note = ({1'b0, r_note} == (fx_count(r_fx) - 3'd1));
    w_gap_done  = (r_state == ST_GAP) && (r_dur == GAP_LAST);
    w_restart   = w_accept || (w_gap_done && !w_last_note);
    w_tone_en   = (r_state == ST_PLAY);
  end

  sfx_tone_gen u_tone (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_restart (w_restart),
    .i_enable  (w_tone_en),
    .i_hp      (w_hp),
    .o_square  (w_square)
  );

  // Sequencer FSM with note index, duration counter and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_fx       <= SFX_NONE;
      r_note     <= 2'd0;
      r_dur      <= {DUR_W{1'b0}};
      r_sample   <= 8'd0;
      r_audio_en <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_sample   <= ((r_state == ST_PLAY) && w_square && (w_hp != {HP_W{1'b0}}) && !i_mute)
                    ? AMPLITUDE : 8'd0;
      r_busy     <= (r_state != ST_IDLE);
      r_audio_en <= (r_state != ST_IDLE) && !i_mute;

      if (w_accept) begin
        r_state <= ST_PLAY;
        r_fx    <= w_evt;
        r_note  <= 2'd0;
        r_dur   <= {DUR_W{1'b0}};
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_dur <= {DUR_W{1'b0}};
          end
          ST_PLAY: begin
            if (r_dur == NOTE_LAST) begin
              r_state <= ST_GAP;
              r_dur   <= {DUR_W{1'b0}};
            end else begin
              r_dur <= r_dur + DUR_W'(1);
            end
          end
          ST_GAP: begin
            if (r_dur == GAP_LAST) begin
              r_dur <= {DUR_W{1'b0}};
              if (w_last_note) begin
                r_state <= ST_IDLE;
                r_fx    <= SFX_NONE;
                r_note  <= 2'd0;
              end else begin
                r_state <= ST_PLAY;
                r_note  <= r_note + 2'd1;
              end
            end else begin
              r_dur <= r_dur + DUR_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_fx    <= SFX_NONE;
            r_note  <= 2'd0;
            r_dur   <= {DUR_W{1'b0}};
          end
        endcase
      end
    end
  end

  assign o_sample_out = r_sample;
  assign o_audio_en   = r_audio_en;
  assign o_busy       = r_busy;

endmodule
